// File: rtl/stack_pkg.sv
// Shared definitions for the stack pointer bank: width helpers and operation encoding.
// Pure declarations, no timing; no backpressure, every operation completes in one cycle.
package stack_pkg;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  function automatic int sel_width(input int num_stacks);
    return (clog2(num_stacks) < 1) ? 1 : clog2(num_stacks);
  endfunction

  function automatic int cnt_width(input int stack_depth);
    return clog2(stack_depth + 1);
  endfunction

  // Widths for the default two-stack, 256-deep configuration.
  localparam int SEL_W = sel_width(2);
  localparam int CNT_W = cnt_width(256);

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_LOAD = 2'd3
  } op_t;

  // Load outranks Write; Pop only matters while Write is set.
  function automatic op_t decode_op(input logic load, input logic write, input logic pop);
    if (load) return OP_LOAD;
    if (write) return pop ? OP_POP : OP_PUSH;
    return OP_HOLD;
  endfunction

endpackage

// File: rtl/stack_counter.sv
// One stack's occupancy count plus sticky overflow/underflow flags.
// New state one edge after the op; never stalls, errors saturate or wrap per WRAP.
module stack_counter
  import stack_pkg::*;
#(
  parameter int STACK_DEPTH = 256,
  parameter int WRAP        = 0,
  parameter int CNT_W       = cnt_width(STACK_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  op_t              op,
  input  logic [CNT_W-1:0] load_val,
  input  logic             clr_err,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             udf
);

  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(STACK_DEPTH);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] count_nxt;
  logic             ovf_set;
  logic             udf_set;

  assign empty = (count == '0);
  assign full  = (count == DEPTH);

  always_comb begin
    count_nxt = count;
    ovf_set   = 1'b0;
    udf_set   = 1'b0;
    case (op)
      OP_LOAD: begin
        if (load_val > DEPTH) begin
          count_nxt = DEPTH;
          ovf_set   = 1'b1;
        end else begin
          count_nxt = load_val;
        end
      end
      OP_PUSH: begin
        if (!full) begin
          count_nxt = count + ONE;
        end else begin
          ovf_set = 1'b1;
          if (WRAP != 0) count_nxt = ONE;
        end
      end
      OP_POP: begin
        if (!empty) begin
          count_nxt = count - ONE;
        end else begin
          udf_set = 1'b1;
          if (WRAP != 0) count_nxt = DEPTH - ONE;
        end
      end
      default: count_nxt = count;
    endcase
  end

  // A fresh error outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      count <= count_nxt;
      ovf   <= ovf_set | (ovf & ~clr_err);
      udf   <= udf_set | (udf & ~clr_err);
    end
  end

endmodule

// File: rtl/stack_pointer_bank.sv
// Bank of independent hardware stack pointers with per-stack memory windows and flags.
// Pointers update on the same edge as the op; no backpressure, back-to-back ops every cycle.
module stack_pointer_bank
  import stack_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter int                NUM_STACKS  = 2,
  parameter int                STACK_DEPTH = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                GROW_DOWN   = 0,
  parameter int                WRAP        = 0,
  localparam int               SEL_BITS    = sel_width(NUM_STACKS),
  localparam int               CNT_BITS    = cnt_width(STACK_DEPTH)
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [SEL_BITS-1:0]          Sel,
  input  logic                         Write,
  input  logic                         Pop,
  input  logic                         Load,
  input  logic [CNT_BITS-1:0]          LoadVal,
  input  logic                         ClrErr,
  output logic [NUM_STACKS*ADDR_W-1:0] PtrOut,
  output logic [ADDR_W-1:0]            SelPtr,
  output logic [ADDR_W-1:0]            SelTop,
  output logic [CNT_BITS-1:0]          SelCount,
  output logic [NUM_STACKS-1:0]        Empty,
  output logic [NUM_STACKS-1:0]        Full,
  output logic [NUM_STACKS-1:0]        Overflow,
  output logic [NUM_STACKS-1:0]        Underflow
);

  op_t                op;
  logic               sel_ok;
  logic [CNT_BITS-1:0] cnt     [NUM_STACKS];
  logic [ADDR_W-1:0]   ptr     [NUM_STACKS];
  logic [ADDR_W-1:0]   top_adr [NUM_STACKS];

  assign op     = decode_op(Load, Write, Pop);
  assign sel_ok = ({1'b0, Sel} < (SEL_BITS + 1)'(NUM_STACKS));

  for (genvar i = 0; i < NUM_STACKS; i++) begin : g_stack
    localparam logic [ADDR_W-1:0] BASE_I = BASE_ADDR + ADDR_W'(i * STACK_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_I = BASE_I + ADDR_W'(STACK_DEPTH - 1);

    op_t               op_i;
    logic [ADDR_W-1:0] cnt_a;

    assign op_i = (sel_ok && (Sel == SEL_BITS'(i))) ? op : OP_HOLD;

    stack_counter #(
      .STACK_DEPTH (STACK_DEPTH),
      .WRAP        (WRAP),
      .CNT_W       (CNT_BITS)
    ) u_cnt (
      .clk      (CLK),
      .rst_n    (RST_N),
      .op       (op_i),
      .load_val (LoadVal),
      .clr_err  (ClrErr),
      .count    (cnt[i]),
      .empty    (Empty[i]),
      .full     (Full[i]),
      .ovf      (Overflow[i]),
      .udf      (Underflow[i])
    );

    // Address arithmetic wraps modulo 2^ADDR_W by construction.
    assign cnt_a      = ADDR_W'(cnt[i]);
    assign ptr[i]     = (GROW_DOWN != 0) ? (LAST_I - cnt_a) : (BASE_I + cnt_a);
    assign top_adr[i] = (GROW_DOWN != 0) ? (ptr[i] + ADDR_W'(1)) : (ptr[i] - ADDR_W'(1));
    assign PtrOut[i*ADDR_W +: ADDR_W] = ptr[i];
  end

  always_comb begin
    SelPtr   = '0;
    SelTop   = '0;
    SelCount = '0;
    for (int i = 0; i < NUM_STACKS; i++) begin
      if (sel_ok && (Sel == SEL_BITS'(i))) begin
        SelPtr   = ptr[i];
        SelTop   = top_adr[i];
        SelCount = cnt[i];
      end
    end
  end

endmodule

// File: tb/tb_stack_pointer_bank.sv
// Directed bench: four bank configurations share one stimulus stream, checked against hand-computed values.
module tb_stack_pointer_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sel;
  logic        write, pop, load, clr_err;
  logic [3:0]  load_val;

  always #5 clk = ~clk;

  // saturating, grow-up
  logic [31:0] sat_ptr;  logic [15:0] sat_sptr, sat_stop; logic [3:0] sat_scnt;
  logic [1:0]  sat_empty, sat_full, sat_ovf, sat_udf;
  // wrapping, grow-up
  logic [31:0] wrp_ptr;  logic [15:0] wrp_sptr, wrp_stop; logic [3:0] wrp_scnt;
  logic [1:0]  wrp_empty, wrp_full, wrp_ovf, wrp_udf;
  // saturating, grow-down
  logic [31:0] dn_ptr;   logic [15:0] dn_sptr, dn_stop;   logic [3:0] dn_scnt;
  logic [1:0]  dn_empty, dn_full, dn_ovf, dn_udf;
  // three stacks, so Sel=3 is out of range
  logic [47:0] odd_ptr;  logic [15:0] odd_sptr, odd_stop; logic [3:0] odd_scnt;
  logic [2:0]  odd_empty, odd_full, odd_ovf, odd_udf;

  stack_pointer_bank #(.ADDR_W(16), .NUM_STACKS(2), .STACK_DEPTH(8), .BASE_ADDR(16'h0100),
                       .GROW_DOWN(0), .WRAP(0)) u_sat (
    .CLK(clk), .RST_N(rst_n), .Sel(sel[0]), .Write(write), .Pop(pop), .Load(load),
    .LoadVal(load_val), .ClrErr(clr_err), .PtrOut(sat_ptr), .SelPtr(sat_sptr),
    .SelTop(sat_stop), .SelCount(sat_scnt), .Empty(sat_empty), .Full(sat_full),
    .Overflow(sat_ovf), .Underflow(sat_udf));

  stack_pointer_bank #(.ADDR_W(16), .NUM_STACKS(2), .STACK_DEPTH(8), .BASE_ADDR(16'h0100),
                       .GROW_DOWN(0), .WRAP(1)) u_wrp (
    .CLK(clk), .RST_N(rst_n), .Sel(sel[0]), .Write(write), .Pop(pop), .Load(load),
    .LoadVal(load_val), .ClrErr(clr_err), .PtrOut(wrp_ptr), .SelPtr(wrp_sptr),
    .SelTop(wrp_stop), .SelCount(wrp_scnt), .Empty(wrp_empty), .Full(wrp_full),
    .Overflow(wrp_ovf), .Underflow(wrp_udf));

  stack_pointer_bank #(.ADDR_W(16), .NUM_STACKS(2), .STACK_DEPTH(8), .BASE_ADDR(16'h0100),
                       .GROW_DOWN(1), .WRAP(0)) u_dn (
    .CLK(clk), .RST_N(rst_n), .Sel(sel[0]), .Write(write), .Pop(pop), .Load(load),
    .LoadVal(load_val), .ClrErr(clr_err), .PtrOut(dn_ptr), .SelPtr(dn_sptr),
    .SelTop(dn_stop), .SelCount(dn_scnt), .Empty(dn_empty), .Full(dn_full),
    .Overflow(dn_ovf), .Underflow(dn_udf));

  stack_pointer_bank #(.ADDR_W(16), .NUM_STACKS(3), .STACK_DEPTH(8), .BASE_ADDR(16'h0100),
                       .GROW_DOWN(0), .WRAP(0)) u_odd (
    .CLK(clk), .RST_N(rst_n), .Sel(sel), .Write(write), .Pop(pop), .Load(load),
    .LoadVal(load_val), .ClrErr(clr_err), .PtrOut(odd_ptr), .SelPtr(odd_sptr),
    .SelTop(odd_stop), .SelCount(odd_scnt), .Empty(odd_empty), .Full(odd_full),
    .Overflow(odd_ovf), .Underflow(odd_udf));

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] s, input logic wr, input logic pp, input logic ld,
                       input logic [3:0] lv, input logic clr);
    sel = s; write = wr; pop = pp; load = ld; load_val = lv; clr_err = clr;
  endtask

  task automatic idle();
    drive(2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #12;
    rst_n = 1'b1;
    #1;
    check_eq("rst_ptr_up",  sat_ptr,   32'h0108_0100);
    check_eq("rst_ptr_dn",  dn_ptr,    32'h010F_0107);
    check_eq("rst_empty",   sat_empty, 2'b11);
    check_eq("rst_full",    sat_full,  2'b00);
    check_eq("rst_ovf",     sat_ovf,   2'b00);
    check_eq("rst_udf",     sat_udf,   2'b00);

    // three back-to-back pushes on stack 0
    drive(2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    tick(3);
    idle();
    check_eq("push3_ptr",   sat_sptr,        16'h0103);
    check_eq("push3_top",   sat_stop,        16'h0102);
    check_eq("push3_cnt",   sat_scnt,        4'd3);
    check_eq("push3_s1",    sat_ptr[31:16],  16'h0108);
    check_eq("push3_dnptr", dn_sptr,         16'h0104);
    check_eq("push3_dntop", dn_stop,         16'h0105);

    // nine pushes on stack 1: one past full
    drive(2'd1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    tick(9);
    check_eq("ovf_full",    sat_full[1],  1'b1);
    check_eq("ovf_cnt",     sat_scnt,     4'd8);
    check_eq("ovf_ptr",     sat_sptr,     16'h0110);
    check_eq("ovf_flag",    sat_ovf,      2'b10);
    check_eq("wrap_cnt",    wrp_scnt,     4'd1);
    check_eq("wrap_ovf",    wrp_ovf,      2'b10);
    drive(2'd1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    tick(1);
    check_eq("clr_set_wins", sat_ovf,     2'b10);
    check_eq("clr_hold_cnt", sat_scnt,    4'd8);
    drive(2'd1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    tick(1);
    idle();
    check_eq("clr_only",    sat_ovf,      2'b00);

    // pop an empty stack 0
    pulse_reset();
    drive(2'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    tick(1);
    idle();
    check_eq("udf_wrap_cnt", wrp_scnt,    4'd7);
    check_eq("udf_wrap_ptr", wrp_sptr,    16'h0107);
    check_eq("udf_wrap_flg", wrp_udf,     2'b01);
    check_eq("udf_sat_cnt",  sat_scnt,    4'd0);
    check_eq("udf_sat_flg",  sat_udf,     2'b01);

    // grow-down load / pop / oversize load
    pulse_reset();
    drive(2'd0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0);
    tick(1);
    check_eq("dn_load_ptr", dn_sptr,      16'h0102);
    check_eq("dn_load_cnt", dn_scnt,      4'd5);
    drive(2'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    tick(1);
    check_eq("dn_pop_ptr",  dn_sptr,      16'h0103);
    check_eq("dn_pop_top",  dn_stop,      16'h0104);
    drive(2'd0, 1'b0, 1'b0, 1'b1, 4'd9, 1'b0);
    tick(1);
    idle();
    check_eq("dn_big_cnt",  dn_scnt,      4'd8);
    check_eq("dn_big_ovf",  dn_ovf,       2'b01);
    check_eq("dn_big_full", dn_full,      2'b01);
    check_eq("dn_big_ptr",  dn_sptr,      16'h00FF);

    // out-of-range Sel on the three-stack bank
    pulse_reset();
    drive(2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    tick(2);
    drive(2'd3, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    tick(1);
    drive(2'd3, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    tick(1);
    drive(2'd3, 1'b0, 1'b0, 1'b1, 4'd9, 1'b0);
    tick(1);
    check_eq("sel3_ptrs",   odd_ptr,      48'h0110_0108_0102);
    check_eq("sel3_sptr",   odd_sptr,     16'h0000);
    check_eq("sel3_stop",   odd_stop,     16'h0000);
    check_eq("sel3_scnt",   odd_scnt,     4'd0);
    check_eq("sel3_ovf",    odd_ovf,      3'b000);
    check_eq("sel3_udf",    odd_udf,      3'b000);
    drive(2'd2, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    tick(1);
    idle();
    check_eq("sel2_sptr",   odd_sptr,     16'h0111);
    check_eq("sel2_stop",   odd_stop,     16'h0110);
    check_eq("sel2_scnt",   odd_scnt,     4'd1);

    // asynchronous reset in the middle of a push stream
    pulse_reset();
    drive(2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    tick(2);
    check_eq("mid_pre_cnt", sat_scnt,     4'd2);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ptr", sat_ptr,      32'h0108_0100);
    check_eq("mid_rst_cnt", sat_scnt,     4'd0);
    check_eq("mid_rst_emp", sat_empty,    2'b11);
    check_eq("mid_rst_dn",  dn_ptr,       32'h010F_0107);
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b1;
    tick(1);
    check_eq("post_rst_cnt", sat_scnt,    4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
